// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner:
// cathode patterns and the leading-zero significance mask.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERN = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit i set when digit i is at or below the most-significant nonzero nibble;
  // digit 0 always counts as significant so an all-zero value still shows "0".
  function automatic logic [15:0] lzs_mask(input logic [63:0] val);
    logic [15:0] m;
    logic        seen;
    m    = 16'h0001;
    seen = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      seen = seen | (val[4*i +: 4] != 4'h0);
      m[i] = m[i] | seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Nibble to active-low cathode pattern; a dark digit drives all segments off.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dark,
  output logic [6:0] o_cat
);

  // Pattern lookup with forced-off override
  always_comb begin
    o_cat = SEG_OFF;
    if (i_dark) begin
      o_cat = SEG_OFF;
    end else begin
      o_cat = SEG_PATTERN[i_nib];
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment controller with blanking, decimal points,
// leading-zero suppression and frame-aligned (tear-free) content commit.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     Blank,
  input  logic                  LZS,
  input  logic                  Load,
  output logic                  Pending,
  output logic                  FrameDone,
  output logic [DIGITS-1:0]     SevenSegAn,
  output logic [6:0]            SevenSegCat,
  output logic                  SevenSegDP
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_sh_val, r_act_val;
  logic [DIGITS-1:0]     r_sh_dp, r_act_dp, r_sh_blank, r_act_blank;
  logic                  r_pending, r_frame_done, r_dp;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_cat;

  logic                  w_tick, w_last, w_boundary;
  logic [15:0]           w_mask;
  logic [3:0]            w_nib;
  logic                  w_sel_dp, w_sel_blank, w_sel_sig, w_dark;
  logic [6:0]            w_cat;

  assign w_tick     = (r_cnt == CW'(DIV - 1));
  assign w_last     = (r_idx == IW'(DIGITS - 1));
  assign w_boundary = w_tick & w_last;
  assign w_mask     = lzs_mask(64'(r_act_val));

  // Refresh divider and digit index
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_last ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow capture and frame-boundary commit; a load in the boundary cycle bypasses the shadow
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_act_val   <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pending   <= 1'b0;
    end else if (Load && w_boundary) begin
      r_act_val   <= Value;
      r_act_dp    <= DP;
      r_act_blank <= Blank;
      r_pending   <= 1'b0;
    end else if (Load) begin
      r_sh_val    <= Value;
      r_sh_dp     <= DP;
      r_sh_blank  <= Blank;
      r_pending   <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_act_val   <= r_sh_val;
      r_act_dp    <= r_sh_dp;
      r_act_blank <= r_sh_blank;
      r_pending   <= 1'b0;
    end else begin
      r_pending   <= r_pending;
    end
  end

  // Per-digit field selection for the currently scanned digit
  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_sig   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_nib       = (r_idx == IW'(i)) ? r_act_val[4*i +: 4] : w_nib;
      w_sel_dp    = (r_idx == IW'(i)) ? r_act_dp[i]         : w_sel_dp;
      w_sel_blank = (r_idx == IW'(i)) ? r_act_blank[i]      : w_sel_blank;
      w_sel_sig   = (r_idx == IW'(i)) ? w_mask[i]           : w_sel_sig;
    end
    w_dark = w_sel_blank | (LZS & ~w_sel_sig);
  end

  seven_seg_decode u_decode (
    .i_nib  (w_nib),
    .i_dark (w_dark),
    .o_cat  (w_cat)
  );

  // Registered display drive and frame pulse
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_an         <= '1;
      r_cat        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_dark ? '1 : ~(DIGITS'(1) << r_idx);
      r_cat        <= w_cat;
      r_dp         <= w_dark | ~w_sel_dp;
      r_frame_done <= w_boundary;
    end
  end

  assign Pending     = r_pending;
  assign FrameDone   = r_frame_done;
  assign SevenSegAn  = r_an;
  assign SevenSegCat = r_cat;
  assign SevenSegDP  = r_dp;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner (DIGITS=8, DIV=1),
// checked every cycle against a frame-level behavioural model.
module tb_seven_seg_scanner;

  localparam int DIGITS = 8;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Value;
  logic [7:0]  DP, Blank;
  logic        LZS, Load;
  logic        Pending, FrameDone, SevenSegDP;
  logic [7:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: edges since reset release, active/shadow content, pending
  int          m_edges;
  logic [31:0] m_val, s_val;
  logic [7:0]  m_dp, m_blank, s_dp, s_blank;
  logic        m_pend;
  logic [7:0]  exp_an;
  logic [6:0]  exp_cat;
  logic        exp_dp, exp_fd, exp_pend;

  seven_seg_scanner #(.DIGITS(DIGITS), .DIV(1)) dut (
    .CLK(CLK), .Reset(Reset), .Value(Value), .DP(DP), .Blank(Blank),
    .LZS(LZS), .Load(Load), .Pending(Pending), .FrameDone(FrameDone),
    .SevenSegAn(SevenSegAn), .SevenSegCat(SevenSegCat), .SevenSegDP(SevenSegDP)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t, edge %0d)", name, act, exp, $time, m_edges);
    end
  endtask

  task automatic check_all();
    cmp("an",        16'(SevenSegAn),  16'(exp_an));
    cmp("cat",       16'(SevenSegCat), 16'(exp_cat));
    cmp("dp",        16'(SevenSegDP),  16'(exp_dp));
    cmp("framedone", 16'(FrameDone),   16'(exp_fd));
    cmp("pending",   16'(Pending),     16'(exp_pend));
  endtask

  task automatic reset_model();
    m_edges = 0;
    m_val = '0; m_dp = '0; m_blank = '0;
    s_val = '0; s_dp = '0; s_blank = '0;
    m_pend = 1'b0;
    exp_an = 8'hFF; exp_cat = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0; exp_pend = 1'b0;
  endtask

  // One clock: model the edge from the applied inputs, then compare at the falling edge
  task automatic step();
    int   d, msd;
    logic dark, bnd;
    @(posedge CLK);
    d   = m_edges % DIGITS;
    bnd = (d == DIGITS - 1);
    msd = 0;
    for (int i = 0; i < DIGITS; i++) if (m_val[4*i +: 4] != 4'h0) msd = i;
    dark    = m_blank[d] || (LZS && d > msd);
    exp_an  = dark ? 8'hFF : ~(8'h01 << d);
    exp_cat = dark ? 7'h7F : seg_tab[m_val[4*d +: 4]];
    exp_dp  = dark ? 1'b1 : ~m_dp[d];
    exp_fd  = bnd;
    if (Load && bnd) begin
      m_val = Value; m_dp = DP; m_blank = Blank; m_pend = 1'b0;
    end else if (Load) begin
      s_val = Value; s_dp = DP; s_blank = Blank; m_pend = 1'b1;
    end else if (bnd && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
    end
    exp_pend = m_pend;
    m_edges++;
    @(negedge CLK);
    check_all();
  endtask

  // Advance until the displayed digit is d (always at least one clock)
  task automatic goto_digit(input int d);
    for (int n = 0; n < DIGITS; n++) begin
      step();
      if (((m_edges - 1) % DIGITS) == d) break;
    end
  endtask

  initial begin
    Reset = 1'b0; Value = '0; DP = '0; Blank = '0; LZS = 1'b0; Load = 1'b0;
    reset_model();
    @(negedge CLK); @(negedge CLK);
    cmp("rst_an", 16'(SevenSegAn), 16'h00FF);
    cmp("rst_cat", 16'(SevenSegCat), 16'h007F);
    cmp("rst_dp", 16'(SevenSegDP), 16'h0001);
    cmp("rst_pend", 16'(Pending), 16'h0000);
    Reset = 1'b1;

    // idle scan of zeros
    step();
    cmp("idle_an0", 16'(SevenSegAn), 16'h00FE);
    cmp("idle_cat0", 16'(SevenSegCat), 16'h0040);
    for (int n = 0; n < 15; n++) step();

    // mid-frame load, committed at the next boundary
    goto_digit(2);
    Value = 32'h12345678; Load = 1'b1;
    step();
    Load = 1'b0;
    cmp("mid_pend", 16'(Pending), 16'h0001);
    goto_digit(0);
    cmp("mid_cat0", 16'(SevenSegCat), 16'h0000);
    cmp("mid_pend_clr", 16'(Pending), 16'h0000);
    goto_digit(7);
    cmp("mid_cat7", 16'(SevenSegCat), 16'h0079);

    // two loads in one frame, last wins, with LZS
    LZS = 1'b1;
    goto_digit(1);
    Value = 32'hAAAAAAAA; Load = 1'b1;
    step();
    Value = 32'h0000BEEF;
    step();
    Load = 1'b0;
    goto_digit(0);
    cmp("two_cat0", 16'(SevenSegCat), 16'h000E);
    goto_digit(3);
    cmp("two_cat3", 16'(SevenSegCat), 16'h0003);
    goto_digit(5);
    cmp("two_an5", 16'(SevenSegAn), 16'h00FF);

    // load in the boundary cycle goes straight to the next frame
    LZS = 1'b0;
    goto_digit(6);
    Value = 32'h00000009; Load = 1'b1;
    step();
    Load = 1'b0;
    cmp("bnd_pend", 16'(Pending), 16'h0000);
    step();
    cmp("bnd_cat0", 16'(SevenSegCat), 16'h0010);

    // blanking and decimal point
    goto_digit(3);
    Value = 32'h0; DP = 8'h02; Blank = 8'h01; Load = 1'b1;
    step();
    Load = 1'b0;
    goto_digit(0);
    cmp("blk_an0", 16'(SevenSegAn), 16'h00FF);
    cmp("blk_cat0", 16'(SevenSegCat), 16'h007F);
    goto_digit(1);
    cmp("dp_an1", 16'(SevenSegAn), 16'h00FD);
    cmp("dp_cat1", 16'(SevenSegCat), 16'h0040);
    cmp("dp_dp1", 16'(SevenSegDP), 16'h0000);

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      Load  = ($urandom_range(0, 3) == 0);
      Value = $urandom;
      if ($urandom_range(0, 1) == 1) Value = Value >> (4 * $urandom_range(0, 7));
      DP    = 8'($urandom);
      Blank = 8'($urandom & $urandom & $urandom);
      LZS   = 1'($urandom_range(0, 1));
      step();
    end
    Load = 1'b0; DP = '0; Blank = '0; LZS = 1'b0;

    // reset mid-frame with a load pending
    goto_digit(2);
    Value = 32'h00000055; Load = 1'b1;
    step();
    Load = 1'b0;
    cmp("rst2_pend_before", 16'(Pending), 16'h0001);
    step();
    Reset = 1'b0;
    #1;
    reset_model();
    cmp("rst2_an", 16'(SevenSegAn), 16'h00FF);
    cmp("rst2_cat", 16'(SevenSegCat), 16'h007F);
    cmp("rst2_dp", 16'(SevenSegDP), 16'h0001);
    cmp("rst2_pend", 16'(Pending), 16'h0000);
    cmp("rst2_fd", 16'(FrameDone), 16'h0000);
    @(negedge CLK);
    Reset = 1'b1;
    step();
    cmp("rst2_an0", 16'(SevenSegAn), 16'h00FE);
    cmp("rst2_cat0", 16'(SevenSegCat), 16'h0040);
    for (int n = 0; n < 2 * DIGITS; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
